icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter DATA_WIDTH, default 32: address and instruction width.
REQ-002 Parameter SETS, default 16: number of direct-mapped lines, power of two.
REQ-003 Parameter WORDS_PER_LINE, default 4: 32-bit words per line, power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 pc  input  DATA_WIDTH  fetch address from the fetch stage; bits [1:0] ignored.
REQ-007 invalidate  input  1  fence.i pulse; clears all lines.
REQ-008 instr  output  DATA_WIDTH  fetched instruction.
REQ-009 stall  output  1  high when instr is not valid this cycle; drives the fetch-stage PC hold.
REQ-010 mem_req  output  1  refill request to backing memory.
REQ-011 mem_addr  output  DATA_WIDTH  word address of the current refill beat.
REQ-012 mem_rvalid  input  1  mem_rdata valid for the presented mem_addr.
REQ-013 mem_rdata  input  DATA_WIDTH  refill data.

Function
REQ-014 The address split SHALL be: offset = pc[log2(WORDS_PER_LINE)+1:2], index = next log2(SETS) bits, tag = remaining upper bits. The defaults give offset [3:2], index [7:4] and tag [31:8].
REQ-015 The storage SHALL be: per-set valid bit, tag and WORDS_PER_LINE data words.
REQ-016 The FSM SHALL have exactly two states, IDLE and REFILL.
REQ-017 In IDLE, hit = valid[index] AND tag match. Hit is combinational: instr = data[index][offset] and stall = 0 in the same cycle (zero-latency hit).
REQ-018 In IDLE on a miss, the block SHALL:
  - drive stall = 1 and instr = 32'h0000_0013 (NOP) combinationally;
  - on the next edge, latch line base = {tag,index,0...}, clear beat counter to 0, and enter REFILL.
REQ-019 In REFILL:
  - mem_req = 1;
  - mem_addr = line base + 4*beat;
  - stall = 1;
  - instr = NOP;
  - pc changes are ignored, and the latched address is used.
REQ-020 On each edge with mem_rvalid = 1 in REFILL, mem_rdata SHALL be written to data[latched index][beat] and beat SHALL increment.
REQ-021 On the beat == WORDS_PER_LINE-1 accept edge, the block SHALL write the tag, set valid, reset beat to 0 and return to IDLE. The next-cycle lookup uses the current pc.
REQ-022 Minimum miss penalty SHALL be 1 + WORDS_PER_LINE cycles with single-cycle memory; each memory wait cycle adds one.
REQ-023 mem_req SHALL be 0 in IDLE, and mem_addr SHALL be 0 in IDLE.
REQ-024 A refill SHALL overwrite the set unconditionally, with no write-back (read-only cache).
REQ-025 The valid bit of the refilled set SHALL remain 0 until the final beat is written; partially filled lines never hit.
REQ-026 invalidate in IDLE SHALL clear all valid bits at the edge. The lookup in that same cycle still uses the old contents.
REQ-027 invalidate in REFILL SHALL take precedence over beat acceptance:
  - clear all valid bits, abort the refill without setting valid, and return to IDLE;
  - mem_req drops the following cycle;
  - backing memory SHALL tolerate an abandoned request.
REQ-028 mem_rvalid in IDLE SHALL be ignored.

Reset
REQ-029 rst SHALL, at the edge:
  - clear all valid bits;
  - set the FSM to IDLE and beat to 0;
  - in the cycle after reset, mem_req = 0 and mem_addr = 0.
REQ-030 rst asserted mid-refill SHALL abort the refill with the same effect as REQ-029; no partial line becomes valid.
REQ-031 Data and tag arrays SHALL need no reset; outputs derived from them SHALL be masked by valid.

Verification
REQ-032 Cold miss: reset, then pc=0x0 with memory returning rdata=addr^0xA5A5_0000 after a 1-cycle wait -> stall=1 for the whole refill; mem_addr 0x0, 0x4, 0x8, 0xC; then stall=0 and instr=0xA5A5_0000.
REQ-033 Line hits: after REQ-032, pc steps 0x4, 0x8, 0xC -> stall=0 each cycle; instr = 0xA5A5_0004, 0xA5A5_0008, 0xA5A5_000C; mem_req=0.
REQ-034 Conflict eviction: pc=0x100 (index 0, tag 1) -> miss and refill of 0x100–0x10C; then pc=0x0 -> miss again, with mem_addr restarting at 0x0.
REQ-035 Invalidate: after a valid line at 0x0, pulse invalidate in IDLE -> the next cycle with pc=0x0 has stall=1 and a refill starts. Pulse invalidate during beat 2 of a refill -> the FSM is in IDLE next cycle, mem_req=0, and the line is not valid.
REQ-036 Reset mid-refill: assert rst after beat 1 of the 0x40 refill -> the next cycle has mem_req=0; then pc=0x40 misses and refills from 0x40.
REQ-037 Stall-held pc: change pc to 0x200 during a 0x0 refill -> mem_addr continues 0x8, 0xC for the 0x0 line, and a 0x200 miss is taken after return to IDLE.

Source files
------------

// File: rtl/icache_if.sv
// Refill bus between the instruction cache and backing memory.
// The cache is the master: it issues word-address requests and receives beats.
interface icache_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req;
   logic [DATA_WIDTH-1:0] mem_addr;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_rvalid, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and
// a word-by-word line refill; invalidate (fence.i) drops every line.
module icache #(
   parameter int DATA_WIDTH     = 32,
   parameter int SETS           = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic                  invalidate,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  stall,
   icache_if.master              mem
);
   localparam int OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int IDX_W   = $clog2(SETS);
   localparam int IDX_LSB = OFF_W + 2;
   localparam int TAG_LSB = IDX_LSB + IDX_W;
   localparam int TAG_W   = DATA_WIDTH - TAG_LSB;
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

   typedef enum logic {IDLE, REFILL} state_t;
   state_t state_q, state_d;

   logic [SETS-1:0]       valid_q;
   logic [TAG_W-1:0]      tag_q  [SETS];
   logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];
   logic [DATA_WIDTH-1:0] base_q;
   logic [OFF_W-1:0]      beat_q;

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx, ref_idx;
   logic [TAG_W-1:0] tag, ref_tag;
   logic             hit, accept, last;
   logic             unused_pc_bits;

   assign off     = pc[IDX_LSB-1:2];
   assign idx     = pc[TAG_LSB-1:IDX_LSB];
   assign tag     = pc[DATA_WIDTH-1:TAG_LSB];
   assign ref_idx = base_q[TAG_LSB-1:IDX_LSB];
   assign ref_tag = base_q[DATA_WIDTH-1:TAG_LSB];
   assign unused_pc_bits = ^pc[1:0];

   assign hit    = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
   // invalidate wins over a beat arriving in the same cycle
   assign accept = (state_q == REFILL) && mem.mem_rvalid && !invalidate;
   assign last   = (beat_q == LAST_BEAT);

   always_comb begin
      instr        = NOP;
      stall        = 1'b1;
      mem.mem_req  = 1'b0;
      mem.mem_addr = '0;
      if (hit) begin
         instr = data_q[idx][off];
         stall = 1'b0;
      end
      if (state_q == REFILL) begin
         mem.mem_req  = 1'b1;
         mem.mem_addr = base_q + DATA_WIDTH'({beat_q, 2'b00});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (!hit) state_d = REFILL;
         REFILL: if (invalidate || (accept && last)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         beat_q  <= '0;
         base_q  <= '0;
      end else begin
         if (state_q == IDLE && !hit) begin
            base_q <= {pc[DATA_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
            beat_q <= '0;
         end
         if (accept) beat_q <= last ? '0 : beat_q + 1'b1;
         if (state_q == REFILL && invalidate) beat_q <= '0;
         if (accept && last) valid_q[ref_idx] <= 1'b1;
         if (invalidate) valid_q <= '0;
      end
   end

   // Tag/data need no reset: every read is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (accept) data_q[ref_idx][beat_q] <= mem.mem_rdata;
      if (accept && last) tag_q[ref_idx] <= ref_tag;
   end
endmodule
